univ_shift_reg: RTL and testbench

- Parametrised WIDTH-bit edge-triggered storage register; next generation of the single-bit D latch/flip-flop cells in ffsandlatches.
- Per-cycle modes: hold, shift right, shift left, parallel load.
- Provides true and complement outputs, serial in/out at both ends, and a shift counter with a done flag.
- Serves as the serialiser/deserialiser building block for later sequential designs.

---
 rtl/univ_shift_reg.sv | 167 ++++++++++++++++
 tb/tb_univ_shift_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// Parametrised universal shift register with hold / shift right / shift left /
// parallel load modes, true and complement outputs, serial taps at both ends
// and a saturating shift counter with a registered done flag.
//
// Parameters:
//   WIDTH      register width in bits (2..64)
//   RESET_VAL  value loaded into q_out while rst_n_in is low
//
// Ports:
//   clk_in       in   1        rising-edge clock
//   rst_n_in     in   1        asynchronous active-low reset
//   en_in        in   1        global enable; 0 freezes all state
//   mode_in      in   2        00 hold, 01 shift right, 10 shift left, 11 load
//   d_in         in   WIDTH    parallel load data
//   ser_msb_in   in   1        bit entering the MSB on shift right
//   ser_lsb_in   in   1        bit entering the LSB on shift left
//   rot_in       in   1        (UNIV_SHREG_ROTATE_EN only) rotate instead of
//                              taking the serial inputs
//   q_out        out  WIDTH    register contents
//   q_comp       out  WIDTH    ~q_out
//   ser_msb_out  out  1        q_out[WIDTH-1]
//   ser_lsb_out  out  1        q_out[0]
//   cnt_out      out  CW       shifts since last load/reset, saturates at WIDTH
//   done_out     out  1        registered flag, high while cnt_out == WIDTH
//
// Optional feature macro: UNIV_SHREG_ROTATE_EN
//   When defined, the rot_in port exists and a shift with rot_in=1 feeds the
//   bit leaving one end back into the other end. Rotates count as shifts.
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       en_in,
    input  logic [1:0]                 mode_in,
    input  logic [WIDTH-1:0]           d_in,
    input  logic                       ser_msb_in,
    input  logic                       ser_lsb_in,
`ifdef UNIV_SHREG_ROTATE_EN
    input  logic                       rot_in,
`endif
    output logic [WIDTH-1:0]           q_out,
    output logic [WIDTH-1:0]           q_comp,
    output logic                       ser_msb_out,
    output logic                       ser_lsb_out,
    output logic [$clog2(WIDTH):0]     cnt_out,
    output logic                       done_out
);

    // Counter is wide enough to hold the value WIDTH itself.
    localparam int              CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             done_reg;
    logic             done_next;

    // -------------------------------------------------------------------------
    // End-fill bits: either the serial inputs or, when rotating, the bit that
    // is leaving the opposite end of the register.
    // -------------------------------------------------------------------------
    logic fill_msb;   // enters bit WIDTH-1 on shift right
    logic fill_lsb;   // enters bit 0 on shift left

`ifdef UNIV_SHREG_ROTATE_EN
    assign fill_msb = rot_in ? q_reg[0]       : ser_msb_in;
    assign fill_lsb = rot_in ? q_reg[WIDTH-1] : ser_lsb_in;
`else
    assign fill_msb = ser_msb_in;
    assign fill_lsb = ser_lsb_in;
`endif

    // -------------------------------------------------------------------------
    // Per-bit next-state selection. Each bit is a 4:1 mux between itself,
    // its upper neighbour, its lower neighbour and the parallel input; the
    // end bits take the fill bits instead of a non-existent neighbour.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] from_upper;   // source bit for shift right
    logic [WIDTH-1:0] from_lower;   // source bit for shift left

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            if (gi == WIDTH - 1) begin : g_top
                assign from_upper[gi] = fill_msb;
            end else begin : g_mid_upper
                assign from_upper[gi] = q_reg[gi+1];
            end

            if (gi == 0) begin : g_bottom
                assign from_lower[gi] = fill_lsb;
            end else begin : g_mid_lower
                assign from_lower[gi] = q_reg[gi-1];
            end

            always_comb begin
                q_next[gi] = q_reg[gi];
                if (en_in) begin
                    case (mode_in)
                        MODE_SHR:  q_next[gi] = from_upper[gi];
                        MODE_SHL:  q_next[gi] = from_lower[gi];
                        MODE_LOAD: q_next[gi] = d_in[gi];
                        default:   q_next[gi] = q_reg[gi];
                    endcase
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Shift counter and done flag. The flag is derived from the next count so
    // it rises on the same edge the count reaches WIDTH.
    // -------------------------------------------------------------------------
    logic is_shift;
    assign is_shift = en_in && ((mode_in == MODE_SHR) || (mode_in == MODE_SHL));

    always_comb begin
        cnt_next = cnt_reg;
        if (en_in && (mode_in == MODE_LOAD)) begin
            cnt_next = '0;
        end else if (is_shift && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign done_next = (cnt_next == CNT_MAX);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q_reg    <= RESET_VAL;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            cnt_reg  <= cnt_next;
            done_reg <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. q_comp and the serial taps are pure functions of q_reg so they
    // can never disagree with q_out.
    // -------------------------------------------------------------------------
    assign q_out       = q_reg;
    assign q_comp      = ~q_reg;
    assign ser_msb_out = q_reg[WIDTH-1];
    assign ser_lsb_out = q_reg[0];
    assign cnt_out     = cnt_reg;
    assign done_out    = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Self-checking bench for univ_shift_reg at WIDTH=8. A behavioural model of
// the register (plain shifts, masks and a saturating integer count) is
// compared against every DUT output on each falling clock edge; directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         ser_msb;
    logic         ser_lsb;
`ifdef UNIV_SHREG_ROTATE_EN
    logic         rot;
`endif
    logic [W-1:0] q_out;
    logic [W-1:0] q_comp;
    logic         ser_msb_out;
    logic         ser_lsb_out;
    logic [3:0]   cnt_out;
    logic         done_out;

    int passed = 0;
    int total  = 0;
    bit compare_on = 0;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .en_in       (en),
        .mode_in     (mode),
        .d_in        (d),
        .ser_msb_in  (ser_msb),
        .ser_lsb_in  (ser_lsb),
`ifdef UNIV_SHREG_ROTATE_EN
        .rot_in      (rot),
`endif
        .q_out       (q_out),
        .q_comp      (q_comp),
        .ser_msb_out (ser_msb_out),
        .ser_lsb_out (ser_lsb_out),
        .cnt_out     (cnt_out),
        .done_out    (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int unsigned m_q;
    int          m_cnt;
    logic        in_msb;
    logic        in_lsb;

`ifdef UNIV_SHREG_ROTATE_EN
    assign in_msb = rot ? m_q[0]   : ser_msb;
    assign in_lsb = rot ? m_q[W-1] : ser_lsb;
`else
    assign in_msb = ser_msb;
    assign in_lsb = ser_lsb;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= 0;
            m_cnt <= 0;
        end else if (en) begin
            if (mode == 2'b01) begin
                m_q   <= (m_q >> 1) | (int'(in_msb) << (W - 1));
                m_cnt <= (m_cnt + 1 > W) ? W : m_cnt + 1;
            end else if (mode == 2'b10) begin
                m_q   <= ((m_q << 1) & ((1 << W) - 1)) | int'(in_lsb);
                m_cnt <= (m_cnt + 1 > W) ? W : m_cnt + 1;
            end else if (mode == 2'b11) begin
                m_q   <= int'(d);
                m_cnt <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // One compare process, every cycle outputs are meaningful.
    always @(negedge clk) begin
        if (compare_on) begin
            check("mdl_q",    64'(q_out),       64'(m_q));
            check("mdl_qc",   64'(q_comp),      64'(~m_q & 32'hFF));
            check("mdl_smsb", 64'(ser_msb_out), 64'((m_q >> (W - 1)) & 1));
            check("mdl_slsb", 64'(ser_lsb_out), 64'(m_q & 1));
            check("mdl_cnt",  64'(cnt_out),     64'(m_cnt));
            check("mdl_done", 64'(done_out),    64'(m_cnt == W));
            $display("cyc t=%0t en=%0b mode=%0b q=%02h cnt=%0d done=%0b",
                     $time, en, mode, q_out, cnt_out, done_out);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after a falling edge.
    // -------------------------------------------------------------------------
    task automatic cyc(input logic e, input logic [1:0] m, input logic [7:0] dv,
                       input logic ms, input logic ls);
        en = e; mode = m; d = dv; ser_msb = ms; ser_lsb = ls;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [7:0] lsb_seq;
    logic [7:0] lpat;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; d = '0; ser_msb = 1'b0; ser_lsb = 1'b0;
`ifdef UNIV_SHREG_ROTATE_EN
        rot = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        compare_on = 1;
        check("rst_q",    64'(q_out),    64'h00);
        check("rst_qc",   64'(q_comp),   64'hFF);
        check("rst_cnt",  64'(cnt_out),  64'd0);
        check("rst_done", 64'(done_out), 64'd0);

        // Load then asynchronous reset between edges.
        cyc(1, 2'b11, 8'hA5, 0, 0);
        check("load_a5", 64'(q_out), 64'hA5);
        rst_n = 1'b0;
        #1;
        check("async_rst_q",  64'(q_out),  64'h00);
        check("async_rst_qc", 64'(q_comp), 64'hFF);
        #1;
        rst_n = 1'b1;

        // Enable low freezes everything.
        cyc(1, 2'b11, 8'hA5, 0, 0);
        repeat (3) cyc(0, 2'b01, 8'h5A, 1, 1);
        check("en0_q",   64'(q_out),   64'hA5);
        check("en0_cnt", 64'(cnt_out), 64'd0);

        // Shift right 8 times; ser_lsb_out seen before each edge is bit i of A5.
        lsb_seq = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("shr_lsb%0d", i), 64'(ser_lsb_out), 64'(lsb_seq[i]));
            if (i == 7) check("shr_done_pre", 64'(done_out), 64'd0);
            cyc(1, 2'b01, 8'hFF, 0, 1);
        end
        check("shr_q",    64'(q_out),    64'h00);
        check("shr_cnt",  64'(cnt_out),  64'd8);
        check("shr_done", 64'(done_out), 64'd1);
        cyc(1, 2'b01, 8'h00, 0, 0);
        check("shr_sat",      64'(cnt_out),  64'd8);
        check("shr_sat_done", 64'(done_out), 64'd1);

        // Hold mode with en=1 ignores d_in and serial inputs.
        cyc(1, 2'b00, 8'h77, 1, 1);
        check("hold_cnt", 64'(cnt_out), 64'd8);

        // Shift left pattern 1,1,0,0,1,0,1,1 from zero.
        cyc(1, 2'b11, 8'h00, 0, 0);
        lpat = 8'b1101_0011;   // bit i = i-th serial bit
        for (int i = 0; i < 8; i++) cyc(1, 2'b10, 8'h00, 0, lpat[i]);
        check("shl_q",    64'(q_out),    64'hCB);
        check("shl_qc",   64'(q_comp),   64'h34);
        check("shl_done", 64'(done_out), 64'd1);
        cyc(1, 2'b11, 8'h3C, 0, 0);
        check("reload_q",    64'(q_out),    64'h3C);
        check("reload_cnt",  64'(cnt_out),  64'd0);
        check("reload_done", 64'(done_out), 64'd0);

        // Alternating directions keep counting.
        cyc(1, 2'b11, 8'h81, 0, 0);
        cyc(1, 2'b10, 8'h00, 1, 1);
        check("alt_q1", 64'(q_out), 64'h03);
        cyc(1, 2'b01, 8'h00, 0, 1);
        check("alt_q2",  64'(q_out),   64'h01);
        check("alt_cnt", 64'(cnt_out), 64'd2);

`ifdef UNIV_SHREG_ROTATE_EN
        cyc(1, 2'b11, 8'h81, 0, 0);
        rot = 1'b1;
        cyc(1, 2'b01, 8'h00, 0, 0);
        check("rotr_q", 64'(q_out), 64'hC0);
        cyc(1, 2'b10, 8'h00, 0, 0);
        cyc(1, 2'b10, 8'h00, 0, 0);
        check("rotl_q",   64'(q_out),   64'h03);
        check("rot_cnt",  64'(cnt_out), 64'd3);
        rot = 1'b0;
`endif

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 40; i++) begin
`ifdef UNIV_SHREG_ROTATE_EN
            rot = 1'($urandom_range(0, 1));
`endif
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        compare_on = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
